// File: rtl/uart_tx_feeder.sv
// Byte FIFO plus launch FSM feeding a UART transmitter: producers push with valid/ready,
// the FSM hands bytes out one at a time as a registered tx_start pulse with sdata.
module uart_tx_feeder #(
    parameter int DEPTH_LOG2 = 4
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  in_valid,
    input  logic [7:0]            in_data,
    output logic                  in_ready,
    output logic [DEPTH_LOG2:0]   count,
    output logic                  idle,
    output logic                  tx_start,
    output logic [7:0]            sdata,
    input  logic                  tx_busy
);

    localparam int DEPTH = 2 ** DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] FULL_CNT = (DEPTH_LOG2 + 1)'(DEPTH);
    localparam logic [DEPTH_LOG2:0] CNT_ONE  = (DEPTH_LOG2 + 1)'(1);
    localparam logic [DEPTH_LOG2-1:0] PTR_ONE = DEPTH_LOG2'(1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ACK  = 2'd1,
        S_BUSY = 2'd2
    } state_t;

    state_t                state, state_nxt;
    logic [1:0]            ack_cnt, ack_cnt_nxt;
    logic [7:0]            mem [DEPTH];
    logic [DEPTH_LOG2-1:0] wr_ptr, rd_ptr;
    logic                  full, empty, push, launch;

    // No bypass: a full FIFO refuses a push even in a cycle that also pops.
    assign full     = (count == FULL_CNT);
    assign empty    = (count == '0);
    assign in_ready = ~full;
    assign push     = in_valid & in_ready;
    assign idle     = empty & (state == S_IDLE) & ~tx_busy;

    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        state_nxt   = state;
        ack_cnt_nxt = ack_cnt;
        launch      = 1'b0;
        case (state)
            S_IDLE: begin
                if (!empty && !tx_busy) begin
                    launch      = 1'b1;
                    ack_cnt_nxt = 2'd0;
                    state_nxt   = S_ACK;
                end
            end
            S_ACK: begin
                // Give up after four cycles without busy; the launched byte is dropped.
                if (tx_busy) begin
                    state_nxt = S_BUSY;
                end else if (ack_cnt == 2'd3) begin
                    state_nxt = S_IDLE;
                end else begin
                    ack_cnt_nxt = ack_cnt + 2'd1;
                end
            end
            S_BUSY: begin
                if (!tx_busy) begin
                    state_nxt = S_IDLE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state    <= S_IDLE;
            ack_cnt  <= 2'd0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            tx_start <= 1'b0;
            sdata    <= 8'h00;
        end else begin
            state    <= state_nxt;
            ack_cnt  <= ack_cnt_nxt;
            tx_start <= launch;
            if (launch) begin
                sdata  <= mem[rd_ptr];
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            if (push) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (push && !launch) begin
                count <= count + CNT_ONE;
            end else if (!push && launch) begin
                count <= count - CNT_ONE;
            end
        end
    end

    // NOTE: the storage array is deliberately not reset; count and pointers define validity.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= in_data;
        end
    end

endmodule
